// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative RV32M divider (div_iter_unit).
package div_pkg;

    localparam int unsigned DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_POST = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    typedef struct packed {
        logic is_signed;
        logic is_rem;
    } div_op_t;

    // Magnitude of a two's-complement operand; pass-through for unsigned ops.
    function automatic logic [DIV_ITER-1:0] abs_val(input logic [DIV_ITER-1:0] v,
                                                    input logic is_signed);
        return (is_signed && v[DIV_ITER-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        if (shifted >= {2'b00, divisor_i}) begin
            rem_o = (XLEN+1)'(shifted - {2'b00, divisor_i});
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = (XLEN+1)'(shifted);
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_FAST_PATH_EN to retire divide-by-zero, overflow and |op1|<|op2| one cycle after accept.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_div_i,
    input  logic [XLEN-1:0]  div_op1_i,
    input  logic [XLEN-1:0]  div_op2_i,
    input  logic             div_op_div_i,
    input  logic             div_op_divu_i,
    input  logic             div_op_rem_i,
    input  logic             div_op_remu_i,
    input  logic [TAG_W-1:0] div_rd_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             wb_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] rd_o
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    div_op_t           op_q, op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic [XLEN:0]     step_rem;
    logic [XLEN-1:0]   step_quo;
    logic              accept;
    div_op_t           req_op;
    logic [XLEN-1:0]   abs_op1, abs_op2;

`ifdef DIV_FAST_PATH_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic              fast_dz, fast_ovf, fast_small;
`endif

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign ready_o = (state_q == DIV_IDLE) || ((state_q == DIV_DONE) && wb_ready_i);
    assign busy_o  = (state_q != DIV_IDLE);
    assign valid_o = (state_q == DIV_DONE);
    assign result_o = result_q;
    assign rd_o     = tag_q;

    // A request alongside a flush is dropped, even if the unit looks ready.
    assign accept = req_div_i && ready_o && !flush_i &&
                    (div_op_div_i || div_op_divu_i || div_op_rem_i || div_op_remu_i);

    always_comb begin
        req_op.is_signed = div_op_div_i || div_op_rem_i;
        req_op.is_rem    = div_op_rem_i || div_op_remu_i;
        abs_op1          = abs_val(div_op1_i, req_op.is_signed);
        abs_op2          = abs_val(div_op2_i, req_op.is_signed);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        tag_d     = tag_q;
`ifdef DIV_FAST_PATH_EN
        fast_dz    = (div_op2_i == '0);
        fast_ovf   = req_op.is_signed && (div_op1_i == INT_MIN) && (div_op2_i == '1);
        fast_small = (abs_op1 < abs_op2);
`endif

        case (state_q)
            DIV_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_POST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV_POST: begin
                if (op_q.is_rem) begin
                    result_d = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
                end else begin
                    result_d = neg_quo_q ? -quo_q : quo_q;
                end
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (wb_ready_i) begin
                    state_d = DIV_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            op_d      = req_op;
            rem_d     = '0;
            quo_d     = abs_op1;
            dvs_d     = abs_op2;
            cnt_d     = '0;
            tag_d     = div_rd_i;
            // Divide-by-zero must keep the all-ones quotient whatever the operand signs.
            neg_quo_d = req_op.is_signed && (div_op1_i[XLEN-1] ^ div_op2_i[XLEN-1]) &&
                        (div_op2_i != '0);
            neg_rem_d = req_op.is_signed && div_op1_i[XLEN-1];
            state_d   = DIV_CALC;
`ifdef DIV_FAST_PATH_EN
            if (fast_dz || fast_ovf || fast_small) begin
                state_d = DIV_DONE;
                if (req_op.is_rem) begin
                    result_d = fast_ovf ? '0 : div_op1_i;
                end else if (fast_dz) begin
                    result_d = '1;
                end else begin
                    result_d = fast_ovf ? INT_MIN : '0;
                end
            end
`endif
        end

        if (flush_i) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            tag_q     <= tag_d;
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Table-driven bench for div_iter_unit plus flush, stall, back-to-back and mid-op reset sequences.
module tb_div_iter_unit;

    localparam int LIMIT = 100;

    logic        clk;
    logic        rst_n;
    logic        req_div;
    logic [31:0] op1, op2;
    logic        op_div, op_divu, op_rem, op_remu;
    logic [4:0]  rd_in;
    logic        flush;
    logic        ready, busy, valid;
    logic        wb_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;   // 0 DIV, 1 DIVU, 2 REM, 3 REMU
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        fast;
        string       name;
    } vec_t;

    vec_t vecs[18];

    div_iter_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_div_i     (req_div),
        .div_op1_i     (op1),
        .div_op2_i     (op2),
        .div_op_div_i  (op_div),
        .div_op_divu_i (op_divu),
        .div_op_rem_i  (op_rem),
        .div_op_remu_i (op_remu),
        .div_rd_i      (rd_in),
        .flush_i       (flush),
        .ready_o       (ready),
        .busy_o        (busy),
        .valid_o       (valid),
        .wb_ready_i    (wb_ready),
        .result_o      (result),
        .rd_o          (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic fast);
`ifdef DIV_FAST_PATH_EN
        return fast ? 1 : 34;
`else
        return (fast === 1'bx) ? 0 : 34;
`endif
    endfunction

    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag);
        op1     = a;
        op2     = b;
        op_div  = (op == 2'd0);
        op_divu = (op == 2'd1);
        op_rem  = (op == 2'd2);
        op_remu = (op == 2'd3);
        rd_in   = tag;
        req_div = 1'b1;
    endtask

    // Call right after the accepting posedge; lat = cycles from accept until valid_o is seen.
    task automatic wait_valid(output int lat);
        @(negedge clk);
        req_div = 1'b0;
        lat = 1;
        while (!valid && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input vec_t v, input logic [4:0] tag);
        int lat;
        drive_req(v.op, v.a, v.b, tag);
        #1;
        chk({v.name, " ready"}, 32'(ready), 32'd1);
        @(posedge clk);
        wait_valid(lat);
        chk({v.name, " latency"}, 32'(lat), 32'(exp_lat(v.fast)));
        chk({v.name, " result"}, result, v.exp);
        chk({v.name, " rd"}, 32'(rd_out), 32'(tag));
        @(negedge clk);
        chk({v.name, " retired"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int lat;
        int vcount;
        logic [31:0] held_res;
        logic [4:0]  held_rd;

        vecs[0]  = '{2'd1, 32'd100,       32'd7,         32'd14,        1'b0, "divu_100_7"};
        vecs[1]  = '{2'd3, 32'd100,       32'd7,         32'd2,         1'b0, "remu_100_7"};
        vecs[2]  = '{2'd0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0, "div_m7_2"};
        vecs[3]  = '{2'd2, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0, "rem_m7_2"};
        vecs[4]  = '{2'd1, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b1, "divu_5_0"};
        vecs[5]  = '{2'd3, 32'd5,         32'd0,         32'd5,         1'b1, "remu_5_0"};
        vecs[6]  = '{2'd0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1, "div_ovf"};
        vecs[7]  = '{2'd2, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b1, "rem_ovf"};
        vecs[8]  = '{2'd0, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  1'b1, "div_m5_0"};
        vecs[9]  = '{2'd2, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1'b1, "rem_m5_0"};
        vecs[10] = '{2'd1, 32'd3,         32'd10,        32'd0,         1'b1, "divu_3_10"};
        vecs[11] = '{2'd2, 32'hFFFFFFFD,  32'd10,        32'hFFFFFFFD,  1'b1, "rem_m3_10"};
        vecs[12] = '{2'd0, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  1'b0, "div_100_m7"};
        vecs[13] = '{2'd2, 32'd100,       32'hFFFFFFF9,  32'd2,         1'b0, "rem_100_m7"};
        vecs[14] = '{2'd1, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0, "divu_max_1"};
        vecs[15] = '{2'd0, 32'h80000000,  32'd2,         32'hC0000000,  1'b0, "div_min_2"};
        vecs[16] = '{2'd3, 32'hFFFFFFFF,  32'h10,        32'hF,         1'b0, "remu_max_16"};
        vecs[17] = '{2'd1, 32'hFFFFFFFF,  32'hFFFFFFFE,  32'd1,         1'b0, "divu_max_maxm1"};

        rst_n    = 1'b0;
        req_div  = 1'b0;
        op1      = '0;
        op2      = '0;
        op_div   = 1'b0;
        op_divu  = 1'b0;
        op_rem   = 1'b0;
        op_remu  = 1'b0;
        rd_in    = '0;
        flush    = 1'b0;
        wb_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset rd", 32'(rd_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i], 5'(i + 1));
        end

        // Flush at T+10: op is dropped, unit ready at T+11, a request beside the flush is ignored.
        drive_req(2'd1, 32'd100, 32'd7, 5'd20);
        @(posedge clk);
        @(negedge clk);
        req_div = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        drive_req(2'd3, 32'd9, 32'd4, 5'd21);
        @(negedge clk);
        flush   = 1'b0;
        req_div = 1'b0;
        #1;
        chk("flush ready", 32'(ready), 32'd1);
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush valid", 32'(valid), 32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        chk("flush no valid", 32'(vcount), 32'd0);
        run_op(vecs[0], 5'd22);

        // Flush while idle with a request on the same cycle.
        flush = 1'b1;
        drive_req(2'd1, 32'd50, 32'd5, 5'd23);
        @(negedge clk);
        flush   = 1'b0;
        req_div = 1'b0;
        #1;
        chk("idle flush busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Writeback stall for 5 cycles, then retire and accept in the same cycle.
        wb_ready = 1'b0;
        drive_req(2'd3, 32'd100, 32'd7, 5'd9);
        #1;
        chk("stall ready", 32'(ready), 32'd1);
        @(posedge clk);
        wait_valid(lat);
        chk("stall latency", 32'(lat), 32'd34);
        held_res = result;
        held_rd  = rd_out;
        chk("stall result", held_res, 32'd2);
        chk("stall ready low", 32'(ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall valid", 32'(valid), 32'd1);
            chk("stall result hold", result, 32'd2);
            chk("stall rd hold", 32'(rd_out), 32'd9);
        end
        wb_ready = 1'b1;
        drive_req(2'd1, 32'd100, 32'd7, 5'd12);
        #1;
        chk("b2b ready", 32'(ready), 32'd1);
        @(posedge clk);
        wait_valid(lat);
        chk("b2b latency", 32'(lat), 32'd34);
        chk("b2b result", result, 32'd14);
        chk("b2b rd", 32'(rd_out), 32'd12);
        @(negedge clk);

        // Asynchronous reset in the middle of a calculation.
        drive_req(2'd0, 32'hFFFFFFF9, 32'd2, 5'd30);
        @(posedge clk);
        @(negedge clk);
        req_div = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset ready", 32'(ready), 32'd1);
        chk("midreset result", result, 32'd0);
        chk("midreset rd", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(vecs[3], 5'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
